// File: rtl/add_sub_acc_if.sv
// Operand/result handshake bundle for add_sub_acc: operands flow in on
// in_valid/in_ready, results flow out on out_valid/out_ready.
interface add_sub_acc_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         sat;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
    logic         z;
    logic [W-1:0] acc;

    modport master (
        output in_valid, a, b, op, sat, acc_clr, out_ready,
        input  in_ready, out_valid, s, c, ovf, z, acc
    );

    modport slave (
        input  in_valid, a, b, op, sat, acc_clr, out_ready,
        output in_ready, out_valid, s, c, ovf, z, acc
    );
endinterface

// File: rtl/add_sub_acc.sv
// Registered W-bit add/subtract unit with accumulator, optional unsigned
// saturation, carry/borrow, signed overflow and zero flags.
module add_sub_acc #(
    parameter int           W        = 8,
    parameter logic [W-1:0] ACC_INIT = '0
) (
    input  logic        clk,
    input  logic        rst,
    add_sub_acc_if.slave bus
);
    logic         is_add;
    logic         is_acc;
    logic         accept;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W:0]   r;
    logic         c_n;
    logic         ovf_n;
    logic [W-1:0] s_n;
    logic         z_n;

    logic         out_valid_q;
    logic [W-1:0] s_q;
    logic         c_q;
    logic         ovf_q;
    logic         z_q;
    logic [W-1:0] acc_q;

    assign is_add = bus.op[0];
    assign is_acc = bus.op[1];
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;

    // Carry and borrow both fall out of bit W of the widened result.
    always_comb begin
        x     = is_acc ? acc_q : bus.a;
        y     = is_acc ? bus.a : bus.b;
        r     = is_add ? ({1'b0, x} + {1'b0, y}) : ({1'b0, x} - {1'b0, y});
        c_n   = r[W];
        ovf_n = is_add ? ((x[W-1] == y[W-1]) && (r[W-1] != x[W-1]))
                       : ((x[W-1] != y[W-1]) && (r[W-1] != x[W-1]));
        s_n   = r[W-1:0];
        if (bus.sat && c_n) begin
            s_n = is_add ? '1 : '0;
        end
        z_n   = (s_n == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= 1'b0;
            ovf_q       <= 1'b0;
            z_q         <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                s_q         <= s_n;
                c_q         <= c_n;
                ovf_q       <= ovf_n;
                z_q         <= z_n;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // A coincident clear overrides the accumulate write-back.
            if (bus.acc_clr) begin
                acc_q <= ACC_INIT;
            end else if (accept && is_acc) begin
                acc_q <= s_n;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;
    assign bus.z         = z_q;
    assign bus.acc       = acc_q;
endmodule

// File: tb/tb_add_sub_acc.sv
// Directed + random bench for add_sub_acc (W=4) with a result scoreboard
// built from an integer reference model.
module tb_add_sub_acc;
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    typedef struct {
        int s;
        int c;
        int ovf;
        int z;
    } res_t;

    logic clk;
    logic rst;
    add_sub_acc_if #(.W(W)) bus ();

    add_sub_acc #(.W(W), .ACC_INIT(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    res_t q[$];
    bit   m_valid;
    int   m_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= HALF) ? v - (1 << W) : v;
    endfunction

    function automatic res_t model(input int x, input int y, input bit add, input bit satv);
        res_t rr;
        int   full;
        int   sres;
        if (add) begin
            full = x + y;
            rr.c = (full > MAXV) ? 1 : 0;
            sres = to_signed(x) + to_signed(y);
        end else begin
            full = x - y;
            rr.c = (x < y) ? 1 : 0;
            sres = to_signed(x) - to_signed(y);
        end
        rr.ovf = (sres > HALF - 1 || sres < -HALF) ? 1 : 0;
        rr.s   = full & MAXV;
        if (satv && rr.c == 1) rr.s = add ? MAXV : 0;
        rr.z   = (rr.s == 0) ? 1 : 0;
        return rr;
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        bit   exp_rdy;
        bit   cons;
        bit   acc_ok;
        res_t rr;
        #1;
        exp_rdy = !m_valid || bus.out_ready;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, m_valid);
        chk("acc", bus.acc, m_acc);
        if (m_valid) begin
            if (q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                chk("s", bus.s, q[0].s);
                chk("c", bus.c, q[0].c);
                chk("ovf", bus.ovf, q[0].ovf);
                chk("z", bus.z, q[0].z);
            end
        end
        cons   = m_valid && bus.out_ready;
        acc_ok = bus.in_valid && exp_rdy;
        if (cons && q.size() > 0) void'(q.pop_front());
        if (acc_ok) begin
            if (bus.op[1]) rr = model(m_acc, int'(bus.a), bus.op[0], bus.sat);
            else           rr = model(int'(bus.a), int'(bus.b), bus.op[0], bus.sat);
            q.push_back(rr);
        end
        if (bus.acc_clr)             m_acc = 0;
        else if (acc_ok && bus.op[1]) m_acc = rr.s;
        if (acc_ok)    m_valid = 1'b1;
        else if (cons) m_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [1:0] o, input int av, input int bv,
                         input bit sv, input bit rdy, input bit clr);
        bus.in_valid  = v;
        bus.op        = o;
        bus.a         = W'(av);
        bus.b         = W'(bv);
        bus.sat       = sv;
        bus.out_ready = rdy;
        bus.acc_clr   = clr;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        m_valid = 1'b0;
        m_acc = 0;
        bus.in_valid = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.sat = 1'b0; bus.out_ready = 1'b1; bus.acc_clr = 1'b0;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_s", bus.s, 0);
        chk("rst_c", bus.c, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_z", bus.z, 0);
        chk("rst_acc", bus.acc, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        drive(1, 2'b01, 9, 8, 0, 1, 0);   // 1, c=1, ovf=1
        chk("add_wrap_s", bus.s, 1);
        chk("add_wrap_ovf", bus.ovf, 1);
        drive(1, 2'b00, 3, 5, 0, 1, 0);   // 14, borrow
        drive(1, 2'b00, 3, 5, 1, 1, 0);   // sat -> 0, z
        drive(1, 2'b01, 12, 7, 1, 1, 0);  // sat -> 15
        drive(1, 2'b11, 6, 0, 1, 1, 0);   // 6
        drive(1, 2'b11, 6, 0, 1, 1, 0);   // 12
        drive(1, 2'b11, 6, 0, 1, 1, 0);   // 15 (clamped)
        chk("acc_after_3", bus.acc, 15);
        drive(1, 2'b10, 4, 0, 0, 1, 0);   // 11
        drive(0, 2'b00, 0, 0, 0, 1, 0);
        chk("acc_after_sub", bus.acc, 11);
        drive(0, 2'b00, 0, 0, 0, 1, 0);

        drive(1, 2'b01, 2, 3, 0, 0, 0);   // result 5, then hold
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b01, 1, 1, 0, 0, 0);
            chk("hold_s", bus.s, 5);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        drive(1, 2'b01, 1, 1, 0, 1, 0);   // accepted same cycle as release
        drive(1, 2'b10, 4, 0, 0, 1, 0);   // acc 11 -> 7
        drive(1, 2'b11, 2, 0, 0, 1, 1);   // s=9, acc cleared
        chk("clr_s", bus.s, 9);
        drive(0, 2'b00, 0, 0, 0, 1, 0);
        chk("clr_acc", bus.acc, 0);

        drive(1, 2'b01, 5, 5, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_s", bus.s, 0);
        chk("arst_acc", bus.acc, 0);
        q.delete();
        m_valid = 1'b0;
        m_acc = 0;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 2'b01, 1, 1, 0, 1, 0);   // first cycle after reset accepts
        drive(0, 2'b00, 0, 0, 0, 1, 0);

        for (int i = 0; i < 60; i++) begin
            drive(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
                  bit'($urandom_range(0, 9) == 0));
        end

        for (int i = 0; i < 5 && m_valid; i++) drive(0, 2'b00, 0, 0, 0, 1, 0);
        chk("drain_out_valid", bus.out_valid, 0);
        chk("drain_sb", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
